hazard_stall_unit: RTL and testbench

Pipeline hazard controller that generates the Stall and Flush controls consumed by the stallable pipeline registers (PC, IF/ID, ID/EX) of the ARM datapath. It detects load-use hazards, holds the front end for the duration of a multi-cycle multiply, and squashes wrong-path instructions on a taken branch. A saturating stall-cycle counter is provided for performance measurement.

---
 rtl/hazard_stall_unit.sv | 114 +++++++++++
 tb/tb_hazard_stall_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// Hazard controller for the stallable PC, IF/ID and ID/EX registers: load-use
// stalls, multi-cycle multiply hold, taken-branch flush and a stall counter.
module hazard_stall_unit #(
    parameter int MUL_CYCLES = 4,
    parameter int REG_W      = 4
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] ID_Rn,
    input  logic [REG_W-1:0] ID_Rm,
    input  logic             ID_UseRn,
    input  logic             ID_UseRm,
    input  logic             EX_MemRead,
    input  logic [REG_W-1:0] EX_Rd,
    input  logic             EX_MulStart,
    input  logic             EX_BranchTaken,
    input  logic             ClrCount,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             Busy,
    output logic [15:0]      StallCount
);

    typedef enum logic {RUN, MUL} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic [15:0] r_stall_count;
    logic        w_load_use;

    assign w_load_use = EX_MemRead &&
                        ((ID_UseRn && (ID_Rn == EX_Rd)) ||
                         (ID_UseRm && (ID_Rm == EX_Rd)));

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        Busy        = 1'b0;

        case (r_state)
            RUN: begin
                if (EX_BranchTaken) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (EX_MulStart) begin
                    StallF      = 1'b1;
                    StallD      = 1'b1;
                    StallE      = 1'b1;
                    Busy        = 1'b1;
                    w_cnt_nxt   = 8'(MUL_CYCLES - 2);
                    w_state_nxt = MUL;
                end else if (w_load_use) begin
                    // Bubble into EX while the front end holds one cycle.
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            MUL: begin
                Busy = 1'b1;
                if (r_cnt != 8'd0) begin
                    StallF    = 1'b1;
                    StallD    = 1'b1;
                    StallE    = 1'b1;
                    w_cnt_nxt = r_cnt - 8'd1;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase

        // Reset silences every control output in the same cycle it is seen.
        if (Reset) begin
            StallF = 1'b0;
            StallD = 1'b0;
            StallE = 1'b0;
            FlushD = 1'b0;
            FlushE = 1'b0;
            Busy   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        // NOTE: state registers use non-blocking assignment so all flops update together.
        if (Reset) begin
            r_state       <= RUN;
            r_cnt         <= 8'd0;
            r_stall_count <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (ClrCount) begin
                r_stall_count <= 16'd0;
            end else if (StallF && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign StallCount = r_stall_count;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboarded bench for hazard_stall_unit: a driver pushes model predictions,
// a monitor on the falling edge pops and compares them against the DUT.
module tb_hazard_stall_unit;

    localparam int MUL_CYCLES = 4;
    localparam int REG_W      = 4;

    typedef struct {
        logic             rst;
        logic [REG_W-1:0] rn;
        logic [REG_W-1:0] rm;
        logic             use_rn;
        logic             use_rm;
        logic             mem_read;
        logic [REG_W-1:0] rd;
        logic             mul;
        logic             br;
        logic             clr;
    } stim_t;

    typedef struct {
        logic        stall_f;
        logic        stall_d;
        logic        stall_e;
        logic        flush_d;
        logic        flush_e;
        logic        busy;
        logic [15:0] count;
    } exp_t;

    logic             clk;
    logic             Reset;
    logic [REG_W-1:0] ID_Rn, ID_Rm, EX_Rd;
    logic             ID_UseRn, ID_UseRm, EX_MemRead, EX_MulStart, EX_BranchTaken, ClrCount;
    logic             StallF, StallD, StallE, FlushD, FlushE, Busy;
    logic [15:0]      StallCount;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Reference model state: cycles of multiply still to run, and stall total.
    int m_mul_left = 0;
    int m_count    = 0;

    hazard_stall_unit #(.MUL_CYCLES(MUL_CYCLES), .REG_W(REG_W)) dut (
        .clk(clk), .Reset(Reset),
        .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_UseRn(ID_UseRn), .ID_UseRm(ID_UseRm),
        .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd), .EX_MulStart(EX_MulStart),
        .EX_BranchTaken(EX_BranchTaken), .ClrCount(ClrCount),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .Busy(Busy), .StallCount(StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, req);
        end
    endtask

    // One cycle of the architectural behaviour; updates model state as the edge would.
    task automatic model_step(input stim_t s, output exp_t e);
        logic hazard;
        e = '{default: '0};
        e.count = 16'(m_count);
        if (s.rst) begin
            m_mul_left = 0;
            m_count    = 0;
            e.count    = 16'd0;
            return;
        end
        hazard = s.mem_read && ((s.use_rn && s.rn == s.rd) || (s.use_rm && s.rm == s.rd));
        if (m_mul_left > 0) begin
            e.busy = 1'b1;
            if (m_mul_left > 1) {e.stall_f, e.stall_d, e.stall_e} = 3'b111;
            m_mul_left--;
        end else if (s.br) begin
            {e.flush_d, e.flush_e} = 2'b11;
        end else if (s.mul) begin
            {e.stall_f, e.stall_d, e.stall_e} = 3'b111;
            e.busy     = 1'b1;
            m_mul_left = MUL_CYCLES - 1;
        end else if (hazard) begin
            {e.stall_f, e.stall_d, e.flush_e} = 3'b111;
        end
        if (s.clr) m_count = 0;
        else if (e.stall_f && m_count < 16'hFFFF) m_count++;
    endtask

    task automatic drive(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        Reset          = s.rst;
        ID_Rn          = s.rn;
        ID_Rm          = s.rm;
        ID_UseRn       = s.use_rn;
        ID_UseRm       = s.use_rm;
        EX_MemRead     = s.mem_read;
        EX_Rd          = s.rd;
        EX_MulStart    = s.mul;
        EX_BranchTaken = s.br;
        ClrCount       = s.clr;
        model_step(s, e);
        exp_q.push_back(e);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t load_use(input logic [REG_W-1:0] r, input logic use_rn);
        stim_t s;
        s = idle();
        s.mem_read = 1'b1;
        s.rd       = r;
        s.rn       = r;
        s.use_rn   = use_rn;
        s.rm       = r + 4'd1;
        return s;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("StallF",     16'(StallF),  16'(e.stall_f));
            check("StallD",     16'(StallD),  16'(e.stall_d));
            check("StallE",     16'(StallE),  16'(e.stall_e));
            check("FlushD",     16'(FlushD),  16'(e.flush_d));
            check("FlushE",     16'(FlushE),  16'(e.flush_e));
            check("Busy",       16'(Busy),    16'(e.busy));
            check("StallCount", StallCount,   e.count);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        Reset = 1'b1;
        {ID_Rn, ID_Rm, EX_Rd} = '0;
        {ID_UseRn, ID_UseRm, EX_MemRead, EX_MulStart, EX_BranchTaken, ClrCount} = '0;

        // Reset with idle and with busy inputs: outputs must stay quiet.
        s = idle(); s.rst = 1'b1;
        drive(s);
        s = load_use(4'd3, 1'b1); s.rst = 1'b1; s.br = 1'b1;
        drive(s);
        repeat (2) drive(idle());

        // Load-use hit, then the same registers without the read enable.
        drive(load_use(4'd3, 1'b1));
        drive(idle());
        drive(load_use(4'd3, 1'b0));
        drive(load_use(4'd15, 1'b1));
        s = idle(); s.mem_read = 1'b1; s.rd = 4'd7; s.rm = 4'd7; s.use_rm = 1'b1;
        drive(s);

        // Full multiply, with junk inputs that MUL must ignore.
        s = idle(); s.mul = 1'b1;
        drive(s);
        s = load_use(4'd2, 1'b1); s.br = 1'b1;
        repeat (MUL_CYCLES - 1) drive(s);
        drive(idle());

        // Reset during the second multiply cycle.
        s = idle(); s.mul = 1'b1;
        drive(s);
        s = idle(); s.rst = 1'b1;
        drive(s);
        repeat (2) drive(idle());

        // Branch beats load-use; branch beats multiply start.
        s = load_use(4'd5, 1'b1); s.br = 1'b1;
        drive(s);
        s = idle(); s.mul = 1'b1; s.br = 1'b1;
        drive(s);
        drive(idle());

        // Randomised traffic over a small register range to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            s.rst      = ($urandom_range(0, 199) == 0);
            s.rn       = 4'($urandom_range(0, 3));
            s.rm       = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            s.rd       = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            s.use_rn   = 1'($urandom_range(0, 1));
            s.use_rm   = 1'($urandom_range(0, 1));
            s.mem_read = 1'($urandom_range(0, 1));
            s.mul      = ($urandom_range(0, 7) == 0);
            s.br       = ($urandom_range(0, 7) == 0);
            s.clr      = ($urandom_range(0, 31) == 0);
            drive(s);
        end

        // Saturation: clear, stall continuously past 0xFFFF, then clear mid-stall.
        s = idle(); s.rst = 1'b1;
        drive(s);
        s = load_use(4'd3, 1'b1);
        for (int i = 0; i < 65534 + 4; i++) drive(s);
        s.clr = 1'b1;
        drive(s);
        s.clr = 1'b0;
        repeat (2) drive(s);
        drive(idle());

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
